// File: rtl/cp0_regs.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regs
// Brief    : MIPS32 CP0 register file, exception/ERET controller and
//            Count/Compare timer interrupt for the five-stage core.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_regs #(
    parameter int          EXT_INT_W  = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter bit          TIMER_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic                 mtc0_we,
    input  logic [4:0]           mtc0_addr,
    input  logic [2:0]           mtc0_sel,
    input  logic [31:0]          mtc0_wdata,
    input  logic [4:0]           rd_addr,
    input  logic [2:0]           rd_sel,
    output logic [31:0]          rd_data,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 eret,
    output logic                 int_pending,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic                 status_exl,
    output logic [31:0]          epc
);

    localparam int                 PRESC_W      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX    = PRESC_W'(COUNT_DIV - 1);
    localparam logic [4:0]         REG_BADVADDR = 5'd8;
    localparam logic [4:0]         REG_COUNT    = 5'd9;
    localparam logic [4:0]         REG_COMPARE  = 5'd11;
    localparam logic [4:0]         REG_STATUS   = 5'd12;
    localparam logic [4:0]         REG_CAUSE    = 5'd13;
    localparam logic [4:0]         REG_EPC      = 5'd14;

    logic [31:0]        badvaddr_q, badvaddr_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic               ti_q, ti_d;
    logic [1:0]         ip_sw_q, ip_sw_d;
    logic [5:0]         ip_hw_q, ip_hw_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;
    logic               flush_q, flush_d;
    logic [31:0]        flush_pc_q, flush_pc_d;

    logic [5:0]  ext_pad;
    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic        mtc0_hit;
    logic        presc_wrap;

    generate
        if (EXT_INT_W >= 6) begin : g_ext_full
            assign ext_pad = ext_int[5:0];
        end else begin : g_ext_pad
            assign ext_pad = {{(6 - EXT_INT_W){1'b0}}, ext_int};
        end
    endgenerate

    assign status_word = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    // IP7 shares the top hardware line with the timer request.
    assign cause_word  = {bd_q, ti_q, 14'd0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                          ip_sw_q, 1'b0, exc_code_q, 2'b00};

    assign int_pending = ie_q & ~exl_q & (|(cause_word[15:8] & im_q));
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;
    assign status_exl  = exl_q;
    assign epc         = epc_q;

    always_comb begin
        rd_data = 32'd0;
        if (rd_sel == 3'd0) begin
            case (rd_addr)
                REG_BADVADDR: rd_data = badvaddr_q;
                REG_COUNT:    rd_data = count_q;
                REG_COMPARE:  rd_data = compare_q;
                REG_STATUS:   rd_data = status_word;
                REG_CAUSE:    rd_data = cause_word;
                REG_EPC:      rd_data = epc_q;
                default:      rd_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = ext_pad;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;

        mtc0_hit   = mtc0_we & ~exc_valid & ~eret & (mtc0_sel == 3'd0);
        presc_wrap = (presc_q == PRESC_MAX);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;

        if (mtc0_hit && (mtc0_addr == REG_COUNT)) begin
            count_d = mtc0_wdata;
            presc_d = '0;
        end else if (presc_wrap) begin
            count_d = count_q + 32'd1;
            if (TIMER_EN && (count_q + 32'd1 == compare_q)) begin
                ti_d = 1'b1;
            end
        end

        if (exc_valid) begin
            if (!exl_q) begin
                epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_bd;
            end
            exl_d      = 1'b1;
            exc_code_d = exc_code;
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_d = exc_badvaddr;
            end
            flush_d    = 1'b1;
            flush_pc_d = EXC_VECTOR;
        end else if (eret) begin
            exl_d      = 1'b0;
            flush_d    = 1'b1;
            flush_pc_d = epc_q;
        end else if (mtc0_hit) begin
            case (mtc0_addr)
                REG_COMPARE: begin
                    compare_d = mtc0_wdata;
                    ti_d      = 1'b0;
                end
                REG_STATUS: begin
                    im_d  = mtc0_wdata[15:8];
                    exl_d = mtc0_wdata[1];
                    ie_d  = mtc0_wdata[0];
                end
                REG_CAUSE: ip_sw_d = mtc0_wdata[9:8];
                REG_EPC:   epc_d   = mtc0_wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            presc_q    <= '0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            flush_q    <= 1'b0;
            flush_pc_q <= 32'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            presc_q    <= presc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_regs
// Brief    : Self-checking bench for cp0_regs: directed scenarios plus random
//            traffic against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_regs;

    localparam int          DIV = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  ext_int = '0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  mtc0_addr = '0;
    logic [2:0]  mtc0_sel = '0;
    logic [31:0] mtc0_wdata = '0;
    logic [4:0]  rd_addr = '0;
    logic [2:0]  rd_sel = '0;
    logic [31:0] rd_data;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_bd = 1'b0;
    logic [31:0] exc_badvaddr = '0;
    logic        eret = 1'b0;
    logic        int_pending;
    logic        flush;
    logic [31:0] flush_pc;
    logic        status_exl;
    logic [31:0] epc;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, held as architectural 32-bit words.
    logic [31:0] m_badv, m_count, m_compare, m_status, m_cause_base, m_epc, m_fpc;
    logic [5:0]  m_ext;
    logic        m_ti, m_flush;
    int          m_div;

    cp0_regs #(
        .EXT_INT_W (6),
        .COUNT_DIV (DIV),
        .EXC_VECTOR(VEC),
        .TIMER_EN  (1'b1)
    ) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel), .mtc0_wdata(mtc0_wdata),
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr), .eret(eret),
        .int_pending(int_pending), .flush(flush), .flush_pc(flush_pc),
        .status_exl(status_exl), .epc(epc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_cause();
        return m_cause_base | (32'(m_ti) << 30) | (32'(m_ext) << 10) | (32'(m_ti) << 15);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_intp();
        logic [31:0] c;
        c = m_cause();
        return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'd0);
    endfunction

    task automatic model_update();
        logic wr;
        if (rst) begin
            m_badv = 0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
            m_cause_base = 0; m_epc = 0; m_fpc = 0; m_ext = 0; m_ti = 0;
            m_flush = 0; m_div = 0;
            return;
        end
        wr = mtc0_we && !exc_valid && !eret && (mtc0_sel == 0);
        if (wr && mtc0_addr == 9) begin
            m_count = mtc0_wdata;
            m_div   = 0;
        end else if (m_div == DIV - 1) begin
            m_div   = 0;
            m_count = m_count + 1;
            if (m_count == m_compare) m_ti = 1;
        end else begin
            m_div = m_div + 1;
        end
        m_ext   = ext_int;
        m_flush = 0;
        if (exc_valid) begin
            if (!m_status[1]) begin
                m_epc = exc_bd ? exc_pc - 4 : exc_pc;
                m_cause_base[31] = exc_bd;
            end
            m_status[1] = 1;
            m_cause_base[6:2] = exc_code;
            if (exc_code == 4 || exc_code == 5) m_badv = exc_badvaddr;
            m_flush = 1;
            m_fpc   = VEC;
        end else if (eret) begin
            m_fpc       = m_epc;
            m_status[1] = 0;
            m_flush     = 1;
        end else if (wr) begin
            case (mtc0_addr)
                5'd11: begin m_compare = mtc0_wdata; m_ti = 0; end
                5'd12: m_status = 32'h0040_0000 | (mtc0_wdata & 32'h0000_FF03);
                5'd13: m_cause_base = (m_cause_base & ~32'h300) | (mtc0_wdata & 32'h300);
                5'd14: m_epc = mtc0_wdata;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        mtc0_we = 0; exc_valid = 0; eret = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1; mtc0_addr = a; mtc0_sel = 0; mtc0_wdata = d;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [3];
        exp_v[0] = 32'h0040_0000; exp_v[1] = 0; exp_v[2] = 0;
        rst = 1; tick(); tick(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 5'(12 + i); rd_sel = 0; #1;
            n_chk++;
            if (rd_data !== exp_v[i]) begin
                n_fail++; $display("FAIL reset_reg%0d got %h want %h", 12 + i, rd_data, exp_v[i]);
            end
        end
        n_chk++;
        if ({int_pending, flush, status_exl, flush_pc} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outs got ip=%b fl=%b exl=%b fpc=%h want 0", int_pending, flush, status_exl, flush_pc);
        end
    endtask

    task automatic test_status_cause();
        mtc0(12, 32'hFFFF_FFFF);
        rd_addr = 12; #1; n_chk++;
        if (rd_data !== 32'h0040_FF03) begin
            n_fail++; $display("FAIL status_mask got %h want 0040ff03", rd_data);
        end
        mtc0(13, 32'hFFFF_FFFF);
        rd_addr = 13; #1; n_chk++;
        if (rd_data !== 32'h0000_0300) begin
            n_fail++; $display("FAIL cause_mask got %h want 00000300", rd_data);
        end
        n_chk++;
        if (int_pending !== 1'b0) begin
            n_fail++; $display("FAIL intp_exl got %b want 0", int_pending);
        end
        mtc0(12, 32'h0000_FF01);
        n_chk++;
        if (int_pending !== 1'b1) begin
            n_fail++; $display("FAIL intp_sw got %b want 1", int_pending);
        end
        mtc0(13, 32'h0); mtc0(12, 32'h0);
    endtask

    task automatic test_timer();
        mtc0(12, 32'h0000_8001);
        mtc0(11, 32'd8);
        mtc0(9, 32'd5);
        rd_addr = 13;
        for (int i = 1; i <= 6; i++) begin
            tick(); n_chk++;
            if (rd_data[30] !== (i == 6)) begin
                n_fail++; $display("FAIL timer_ti cycle%0d got %b want %b", i, rd_data[30], (i == 6));
            end
        end
        n_chk++;
        if (int_pending !== 1'b1 || m_intp() !== 1'b1) begin
            n_fail++; $display("FAIL timer_intp got %b want 1", int_pending);
        end
        mtc0(11, 32'h0000_FFFF);
        n_chk++;
        if (rd_data[30] !== 1'b0 || int_pending !== 1'b0) begin
            n_fail++; $display("FAIL timer_clear got ti=%b ip=%b want 0/0", rd_data[30], int_pending);
        end
    endtask

    task automatic test_exception();
        exc_valid = 1; exc_code = 4; exc_pc = 32'h1000; exc_bd = 1; exc_badvaddr = 32'h2003;
        tick();
        n_chk++;
        if (flush !== 1'b1 || flush_pc !== VEC) begin
            n_fail++; $display("FAIL exc_flush got %b/%h want 1/%h", flush, flush_pc, VEC);
        end
        n_chk++;
        if (epc !== 32'h0FFC || status_exl !== 1'b1) begin
            n_fail++; $display("FAIL exc_epc got %h exl=%b want 00000ffc exl=1", epc, status_exl);
        end
        rd_addr = 13; #1; n_chk++;
        if (rd_data[31] !== 1'b1 || rd_data[6:2] !== 5'd4) begin
            n_fail++; $display("FAIL exc_cause got %h want bd=1 code=4", rd_data);
        end
        rd_addr = 8; #1; n_chk++;
        if (rd_data !== 32'h2003) begin
            n_fail++; $display("FAIL exc_badv got %h want 00002003", rd_data);
        end
        tick(); n_chk++;
        if (flush !== 1'b0) begin
            n_fail++; $display("FAIL exc_pulse got %b want 0", flush);
        end
    endtask

    task automatic test_back_to_back();
        exc_valid = 1; exc_code = 8; exc_pc = 32'h3000; exc_bd = 0; exc_badvaddr = 32'h5555;
        tick();
        rd_addr = 13; #1; n_chk++;
        if (epc !== 32'h0FFC || rd_data[6:2] !== 5'd8 || flush !== 1'b1) begin
            n_fail++; $display("FAIL nested_exc got epc=%h code=%0d fl=%b want 00000ffc/8/1", epc, rd_data[6:2], flush);
        end
        rd_addr = 8; #1; n_chk++;
        if (rd_data !== 32'h2003) begin
            n_fail++; $display("FAIL nested_badv got %h want 00002003", rd_data);
        end
        eret = 1; tick(); n_chk++;
        if (flush !== 1'b1 || flush_pc !== 32'h0FFC || status_exl !== 1'b0) begin
            n_fail++; $display("FAIL eret got fl=%b fpc=%h exl=%b want 1/00000ffc/0", flush, flush_pc, status_exl);
        end
        tick();
    endtask

    task automatic test_priority();
        exc_valid = 1; exc_code = 12; exc_pc = 32'h4000; exc_bd = 0;
        eret = 1; mtc0_we = 1; mtc0_addr = 14; mtc0_sel = 0; mtc0_wdata = 32'hDEAD;
        tick(); n_chk++;
        if (epc !== 32'h4000 || status_exl !== 1'b1 || flush_pc !== VEC) begin
            n_fail++; $display("FAIL prio_exc got epc=%h exl=%b fpc=%h want 00004000/1/%h", epc, status_exl, flush_pc, VEC);
        end
        eret = 1; mtc0_we = 1; mtc0_addr = 12; mtc0_wdata = 32'h0;
        tick();
        rd_addr = 12; #1; n_chk++;
        if (rd_data !== 32'h0040_8001 || flush_pc !== 32'h4000 || flush !== 1'b1) begin
            n_fail++; $display("FAIL prio_eret got st=%h fpc=%h fl=%b want 00408001/00004000/1", rd_data, flush_pc, flush);
        end
    endtask

    task automatic test_count_wrap();
        mtc0(9, 32'hFFFF_FFFF);
        rd_addr = 9; tick(); n_chk++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_hold got %h want ffffffff", rd_data);
        end
        tick(); n_chk++;
        if (rd_data !== 32'h0) begin
            n_fail++; $display("FAIL wrap_zero got %h want 00000000", rd_data);
        end
    endtask

    task automatic test_random();
        logic [4:0] addrs [8];
        logic [4:0] codes [7];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            ext_int      = 6'($urandom);
            mtc0_we      = ($urandom_range(0, 2) == 0);
            mtc0_addr    = addrs[$urandom_range(0, 7)];
            mtc0_sel     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            mtc0_wdata   = $urandom;
            if (mtc0_addr == 11 && $urandom_range(0, 1) == 1)
                mtc0_wdata = m_count + $urandom_range(1, 8);
            exc_valid    = ($urandom_range(0, 7) == 0);
            exc_code     = codes[$urandom_range(0, 6)];
            exc_pc       = $urandom & 32'hFFFF_FFFC;
            exc_bd       = 1'($urandom);
            exc_badvaddr = $urandom;
            eret         = ($urandom_range(0, 7) == 0);
            rd_addr      = addrs[$urandom_range(0, 7)];
            rd_sel       = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
            #1; n_chk++;
            if (rd_data !== m_read(rd_addr, rd_sel)) begin
                n_fail++; $display("FAIL rand_read it%0d reg%0d sel%0d got %h want %h", i, rd_addr, rd_sel, rd_data, m_read(rd_addr, rd_sel));
            end
            tick(); n_chk++;
            if (flush !== m_flush || flush_pc !== m_fpc || int_pending !== m_intp()
                || status_exl !== m_status[1] || epc !== m_epc) begin
                n_fail++; $display("FAIL rand_outs it%0d got fl=%b fpc=%h ip=%b exl=%b epc=%h want %b/%h/%b/%b/%h",
                    i, flush, flush_pc, int_pending, status_exl, epc, m_flush, m_fpc, m_intp(), m_status[1], m_epc);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_status_cause();
        test_timer();
        test_exception();
        test_back_to_back();
        test_priority();
        test_count_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
